fp_compare_pipe: RTL and testbench

A pipelined, parametrised IEEE-754 comparator for any binary format; single precision is the default. It returns full relational flags, an unordered flag, and minNum/maxNum results. Inputs and outputs use valid/ready handshakes and honour backpressure. A saturating NaN-event counter provides diagnostics. It replaces the earlier combinational single-precision comparator in the FP datapath.

---
 rtl/fp_cmp_pkg.sv | 20 ++
 rtl/fp_compare_pipe_classify.sv | 31 +++
 rtl/fp_compare_pipe.sv | 158 +++++++++++++++
 tb/tb_fp_compare_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared types and constants for the pipelined IEEE-754 comparator.
// Classification enum plus the canonical quiet NaN builder used for the both-NaN min/max result.
package fp_cmp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_W     = 128;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

    // {0, all-ones exponent, mantissa MSB set, rest zero}, right-aligned in MAX_W bits
    function automatic logic [MAX_W-1:0] qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] r;
        r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
        r = r | (MAX_W'(1) << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_compare_pipe_classify.sv
// Combinational per-operand decode: class, sign and the unsigned {exp,man} magnitude.
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [EXP_W+MAN_W:0]   x,
    output fp_class_t              cls,
    output logic                   sign,
    output logic [EXP_W+MAN_W-1:0] mag
);

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;

    assign sign = x[EXP_W+MAN_W];
    assign e    = x[EXP_W+MAN_W-1:MAN_W];
    assign m    = x[MAN_W-1:0];
    assign mag  = x[EXP_W+MAN_W-1:0];

    always_comb begin
        cls = NORM;
        if (e == '0) begin
            cls = (m == '0) ? ZERO : SUB;
        end else if (e == '1) begin
            cls = (m == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage IEEE-754 comparator: S1 classifies and compares magnitudes, S2 resolves flags and min/max.
// Handshake: a pair/result moves when valid && ready; ready never waits on valid, valid never waits on ready.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 eq,
    output logic                 lt,
    output logic                 gt,
    output logic                 unordered,
    output logic [EXP_W+MAN_W:0] min_o,
    output logic [EXP_W+MAN_W:0] max_o,
    output logic [CNT_W-1:0]     nan_cnt,
    input  logic                 cnt_clr
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam int M = EXP_W + MAN_W;
    localparam logic [MAX_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

    fp_class_t      cls_a, cls_b;
    logic           sgn_a, sgn_b;
    logic [M-1:0]   mag_a, mag_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(a), .cls(cls_a), .sign(sgn_a), .mag(mag_a));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(b), .cls(cls_b), .sign(sgn_b), .mag(mag_b));

    logic           s1_valid;
    logic [W-1:0]   s1_a, s1_b;
    fp_class_t      s1_cls_a, s1_cls_b;
    logic           s1_sgn_a, s1_sgn_b;
    logic           s1_mag_lt, s1_mag_eq;

    logic           s1_adv, s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_cls_a  <= ZERO;
            s1_cls_b  <= ZERO;
            s1_sgn_a  <= 1'b0;
            s1_sgn_b  <= 1'b0;
            s1_mag_lt <= 1'b0;
            s1_mag_eq <= 1'b0;
        end else if (s1_adv) begin
            s1_valid  <= in_valid;
            s1_a      <= a;
            s1_b      <= b;
            s1_cls_a  <= cls_a;
            s1_cls_b  <= cls_b;
            s1_sgn_a  <= sgn_a;
            s1_sgn_b  <= sgn_b;
            s1_mag_lt <= (mag_a < mag_b);
            s1_mag_eq <= (mag_a == mag_b);
        end
    end

    logic         a_nan, b_nan, both_zero;
    logic         r_eq, r_lt, r_gt, r_un;
    logic [W-1:0] r_min, r_max;

    assign a_nan     = (s1_cls_a == NAN);
    assign b_nan     = (s1_cls_b == NAN);
    assign both_zero = (s1_cls_a == ZERO) && (s1_cls_b == ZERO);

    always_comb begin
        r_eq  = 1'b0;
        r_lt  = 1'b0;
        r_gt  = 1'b0;
        r_un  = 1'b0;
        r_min = s1_a;
        r_max = s1_a;
        if (a_nan || b_nan) begin
            r_un = 1'b1;
            if (a_nan && b_nan) begin
                r_min = QNAN;
                r_max = QNAN;
            end else if (a_nan) begin
                r_min = s1_b;
                r_max = s1_b;
            end
        end else if (both_zero) begin
            // -0 is the minimum of a mixed-sign zero pair
            r_eq  = 1'b1;
            r_min = {s1_sgn_a | s1_sgn_b, {M{1'b0}}};
            r_max = {s1_sgn_a & s1_sgn_b, {M{1'b0}}};
        end else begin
            if (s1_sgn_a != s1_sgn_b) begin
                r_lt = s1_sgn_a;
                r_gt = s1_sgn_b;
            end else if (s1_mag_eq) begin
                r_eq = 1'b1;
            end else if (s1_mag_lt ^ s1_sgn_a) begin
                r_lt = 1'b1;
            end else begin
                r_gt = 1'b1;
            end
            if (r_lt) begin
                r_min = s1_a;
                r_max = s1_b;
            end else if (r_gt) begin
                r_min = s1_b;
                r_max = s1_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            unordered <= 1'b0;
            min_o     <= '0;
            max_o     <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            eq        <= s1_valid & r_eq;
            lt        <= s1_valid & r_lt;
            gt        <= s1_valid & r_gt;
            unordered <= s1_valid & r_un;
            min_o     <= s1_valid ? r_min : '0;
            max_o     <= s1_valid ? r_max : '0;
        end
    end

    // Counted as the pair leaves S1, so stalled or reset-discarded pairs are never double counted
    logic nan_inc;
    assign nan_inc = s1_valid && s2_adv && (a_nan || b_nan);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            nan_cnt <= '0;
        end else if (nan_inc && (nan_cnt != '1)) begin
            nan_cnt <= nan_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: directed vector table, randomized backpressured stream against
// an integer-key reference model, reset/counter sequences, and a double-precision CNT_W=2 instance.
module tb_fp_compare_pipe;

    localparam logic [3:0] EQ = 4'b1000;
    localparam logic [3:0] LT = 4'b0100;
    localparam logic [3:0] GT = 4'b0010;
    localparam logic [3:0] UN = 4'b0001;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] mn;
        logic [31:0] mx;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  flags;
        logic [31:0] mn;
        logic [31:0] mx;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [31:0] a, b, min_o, max_o;
    logic        eq, lt, gt, unordered;
    logic [15:0] nan_cnt;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_cnt_clr;
    logic [63:0] d_a, d_b, d_min, d_max;
    logic        d_eq, d_lt, d_gt, d_un;
    logic [1:0]  d_nan_cnt;

    fp_compare_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .eq(eq), .lt(lt), .gt(gt),
        .unordered(unordered), .min_o(min_o), .max_o(max_o), .nan_cnt(nan_cnt), .cnt_clr(cnt_clr)
    );

    fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .CNT_W(2)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .eq(d_eq), .lt(d_lt), .gt(d_gt),
        .unordered(d_un), .min_o(d_min), .max_o(d_max), .nan_cnt(d_nan_cnt), .cnt_clr(d_cnt_clr)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   model_cnt = 0;
    int   sent = 0;
    logic hold_pend = 1'b0;
    res_t held;
    res_t exp_q[$];
    vec_t tbl[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic is_nan32(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Signed integer key: IEEE ordering of non-NaN values equals integer ordering of this key
    function automatic longint key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t   r;
        longint kx, ky;
        r.flags = 4'b0000;
        r.mn    = x;
        r.mx    = x;
        if (is_nan32(x) || is_nan32(y)) begin
            r.flags = UN;
            if (is_nan32(x) && is_nan32(y)) begin
                r.mn = 32'h7FC00000;
                r.mx = 32'h7FC00000;
            end else if (is_nan32(x)) begin
                r.mn = y;
                r.mx = y;
            end
        end else begin
            kx = key(x);
            ky = key(y);
            if (kx == ky) begin
                r.flags = EQ;
                if (kx == 0) begin
                    r.mn = {x[31] | y[31], 31'd0};
                    r.mx = {x[31] & y[31], 31'd0};
                end
            end else if (kx < ky) begin
                r.flags = LT;
                r.mn = x;
                r.mx = y;
            end else begin
                r.flags = GT;
                r.mn = y;
                r.mx = x;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [22:0] m;
        int          k;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        k = $urandom_range(0, 9);
        case (k)
            0:       return {s, 8'h00, 23'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, (m == 23'd0) ? 23'd1 : m};
            3:       return {s, 8'h00, m};
            default: return {s, 8'($urandom_range(1, 254)), m};
        endcase
    endfunction

    task automatic monitor();
        res_t cur, e;
        cur = '{flags: {eq, lt, gt, unordered}, mn: min_o, mx: max_o};
        if (hold_pend) begin
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_data", 128'(cur), 128'(held));
        end
        if (!rst && in_valid && in_ready) begin
            e = model(a, b);
            exp_q.push_back(e);
            sent++;
            if (e.flags == UN) model_cnt++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: actual %0h, required no result", cur);
            end else begin
                e = exp_q.pop_front();
                check("stream_res", 128'(cur), 128'(e));
                check("one_hot", 128'($countones(cur.flags)), 128'(1));
            end
        end
        hold_pend = out_valid && !out_ready;
        held      = cur;
    endtask

    task automatic run_stream(input int n, input int vpct, input int rpct);
        logic [31:0] x, y;
        int          sel;
        sent      = 0;
        hold_pend = 1'b0;
        for (int cyc = 0; cyc < n * 20 + 50; cyc++) begin
            x   = rand_op();
            sel = $urandom_range(0, 5);
            y   = (sel == 0) ? x : (sel == 1) ? (x ^ 32'h80000000) : rand_op();
            in_valid  = (sent < n) && ($urandom_range(0, 99) < vpct);
            a         = x;
            b         = y;
            out_ready = ($urandom_range(0, 99) < rpct);
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            if (sent == n && exp_q.size() == 0) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_drained", 128'(exp_q.size() + (n - sent)), 128'(0));
    endtask

    task automatic apply_vec(input vec_t v);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b1;
        @(negedge clk);
        check("vec_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("vec_lat_early", 128'(out_valid), 128'(0));
        @(posedge clk);
        @(negedge clk);
        if (v.flags == UN) model_cnt++;
        check("vec_valid", 128'(out_valid), 128'(1));
        check("vec_flags", 128'({eq, lt, gt, unordered}), 128'(v.flags));
        check("vec_min", 128'(min_o), 128'(v.mn));
        check("vec_max", 128'(max_o), 128'(v.mx));
        check("vec_nan_cnt", 128'(nan_cnt), 128'(model_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic d_apply(input logic [63:0] x, input logic [63:0] y, input logic [3:0] f,
                           input logic [63:0] mn, input logic [63:0] mx);
        d_in_valid = 1'b1;
        d_a        = x;
        d_b        = y;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("d_valid", 128'(d_out_valid), 128'(1));
        check("d_flags", 128'({d_eq, d_lt, d_gt, d_un}), 128'(f));
        check("d_min", 128'(d_min), 128'(mn));
        check("d_max", 128'(d_max), 128'(mx));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int any_out;

        tbl[0]  = '{32'h40ACCCCD, 32'h40ACCCCD, EQ, 32'h40ACCCCD, 32'h40ACCCCD};
        tbl[1]  = '{32'hC0ACCCCD, 32'hC0ACCCCD, EQ, 32'hC0ACCCCD, 32'hC0ACCCCD};
        tbl[2]  = '{32'h40E66666, 32'h40C9999A, GT, 32'h40C9999A, 32'h40E66666};
        tbl[3]  = '{32'h40C9999A, 32'h40E66666, LT, 32'h40C9999A, 32'h40E66666};
        tbl[4]  = '{32'hC0C9999A, 32'hC0E66666, GT, 32'hC0E66666, 32'hC0C9999A};
        tbl[5]  = '{32'hC0E66666, 32'hC0C9999A, LT, 32'hC0E66666, 32'hC0C9999A};
        tbl[6]  = '{32'h00000000, 32'h80000000, EQ, 32'h80000000, 32'h00000000};
        tbl[7]  = '{32'h80000000, 32'h00000000, EQ, 32'h80000000, 32'h00000000};
        tbl[8]  = '{32'h7FC00000, 32'h3F800000, UN, 32'h3F800000, 32'h3F800000};
        tbl[9]  = '{32'h7FC00000, 32'h7F800001, UN, 32'h7FC00000, 32'h7FC00000};
        tbl[10] = '{32'h7F800000, 32'h7F800000, EQ, 32'h7F800000, 32'h7F800000};
        tbl[11] = '{32'hBF800000, 32'h3F800000, LT, 32'hBF800000, 32'h3F800000};
        tbl[12] = '{32'h3F800000, 32'hFF800000, GT, 32'hFF800000, 32'h3F800000};
        tbl[13] = '{32'h00000001, 32'h80000001, GT, 32'h80000001, 32'h00000001};
        tbl[14] = '{32'h3F800000, 32'h7F800001, UN, 32'h3F800000, 32'h3F800000};
        tbl[15] = '{32'h80000000, 32'h80000000, EQ, 32'h80000000, 32'h80000000};

        rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b1;  cnt_clr = 1'b0;  a = '0;  b = '0;
        d_in_valid = 1'b0;  d_out_ready = 1'b1;  d_cnt_clr = 1'b0;  d_a = '0;  d_b = '0;

        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_flags", 128'({eq, lt, gt, unordered}), 128'(0));
        check("rst_minmax", 128'({min_o, max_o}), 128'(0));
        check("rst_nan_cnt", 128'(nan_cnt), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) apply_vec(tbl[i]);

        run_stream(8, 100, 50);
        check("bp_nan_cnt", 128'(nan_cnt), 128'(model_cnt));
        run_stream(300, 70, 70);
        check("rand_nan_cnt", 128'(nan_cnt), 128'(model_cnt));

        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr", 128'(nan_cnt), 128'(0));

        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b1;
        a = 32'h7FC00000;
        b = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("stall_nan_cnt", 128'(nan_cnt), 128'(1));
        check("stall_out_valid", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_nan_cnt", 128'(nan_cnt), 128'(0));
        check("mid_rst_flags", 128'({eq, lt, gt, unordered}), 128'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        any_out = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) any_out++;
            @(posedge clk);
            #1;
        end
        check("mid_rst_discard", 128'(any_out), 128'(0));
        check("mid_rst_cnt_after", 128'(nan_cnt), 128'(0));
        exp_q.delete();
        model_cnt = 0;

        d_apply(64'h4015_9999_9999_999A, 64'h4015_9999_9999_999A, EQ,
                64'h4015_9999_9999_999A, 64'h4015_9999_9999_999A);
        d_apply(64'h7FF0_0000_0000_0001, 64'hFFF8_0000_0000_0000, UN,
                64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000);
        d_apply(64'hC000_0000_0000_0000, 64'h3FF0_0000_0000_0000, LT,
                64'hC000_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        @(negedge clk);
        check("d_cnt_one", 128'(d_nan_cnt), 128'(1));
        @(posedge clk);
        #1 d_in_valid = 1'b1;
        d_a = 64'h7FF8_0000_0000_0000;
        d_b = 64'h3FF0_0000_0000_0000;
        repeat (5) @(posedge clk);
        #1 d_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("d_cnt_sat", 128'(d_nan_cnt), 128'(3));
        @(posedge clk);
        #1 d_cnt_clr = 1'b1;
        @(posedge clk);
        #1 d_cnt_clr = 1'b0;
        d_in_valid = 1'b1;
        repeat (1) @(posedge clk);
        #1 d_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("d_cnt_after_clr", 128'(d_nan_cnt), 128'(1));
        @(posedge clk);
        #1 d_in_valid = 1'b1;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        d_cnt_clr = 1'b1;
        @(posedge clk);
        #1 d_cnt_clr = 1'b0;
        @(negedge clk);
        check("d_clr_wins", 128'(d_nan_cnt), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("d_clr_hold", 128'(d_nan_cnt), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
